divider_32: RTL and testbench

Multi-cycle 32-bit integer divider sitting beside the combinational 32-bit ALU in the datapath. It handles the MIPS DIV/DIVU function codes that the single-cycle ALU does not implement, and returns quotient and remainder in LO/HI form. It uses the same operand names (`a`, `b`) and the same 6-bit function select as the ALU. It computes one quotient bit per clock with a restoring shift-subtract loop and a start/busy/done handshake.

---
 rtl/divider_32.sv | 129 ++++++++++++
 tb/tb_divider_32.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/divider_32.sv
// Multi-cycle 32-bit DIV/DIVU unit: restoring shift-subtract, one quotient bit per clock.
// Results are returned in MIPS LO (quotient) / HI (remainder) form with a start/busy/done handshake.
module divider_32 #(
  parameter logic [5:0] DIV  = 6'd26,
  parameter logic [5:0] DIVU = 6'd27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [5:0]  sel,
  output logic        busy,
  output logic        done,
  output logic [31:0] lo,
  output logic [31:0] hi,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t      state_q, state_d;
  logic [32:0] r_q, r_d;
  logic [31:0] q_q, q_d;
  logic [31:0] b_q, b_d;
  logic [31:0] a_q, a_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        dz_q, dz_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [32:0] r_sh;
  logic [33:0] trial;

  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    q_d       = q_q;
    b_d       = b_q;
    a_d       = a_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    cnt_d     = cnt_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    signed_op = (sel == DIV);
    // {R,Q} shifted left by one; trial subtract borrows into bit 33 when R < |b|
    r_sh      = {r_q[31:0], q_q[31]};
    trial     = {1'b0, r_sh} - {2'b00, b_q};

    case (state_q)
      IDLE: begin
        if (start && (sel == DIV || sel == DIVU)) begin
          a_d     = a;
          q_d     = (signed_op && a[31]) ? -a : a;
          b_d     = (signed_op && b[31]) ? -b : b;
          r_d     = '0;
          cnt_d   = '0;
          qneg_d  = signed_op & (a[31] ^ b[31]);
          rneg_d  = signed_op & a[31];
          state_d = (b == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        r_d   = trial[33] ? r_sh : trial[32:0];
        q_d   = {q_q[30:0], ~trial[33]};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (b_q == '0) begin
          lo_d = '1;
          hi_d = a_q;
          dz_d = 1'b1;
        end else begin
          lo_d = qneg_q ? -q_q : q_q;
          hi_d = rneg_q ? -r_q[31:0] : r_q[31:0];
          dz_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      b_q     <= '0;
      a_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      b_q     <= b_d;
      a_q     <= a_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == CALC) || (state_q == FIX);
  assign done     = done_q;
  assign lo       = lo_q;
  assign hi       = hi_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_divider_32.sv
// Self-checking bench for divider_32: directed vector table, handshake corner cases,
// and randomized back-to-back divides against a plain-arithmetic reference model.
module tb_divider_32;

  localparam logic [5:0] DIV  = 6'd26;
  localparam logic [5:0] DIVU = 6'd27;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [5:0]  sel;
  logic        busy, done, div_zero;
  logic [31:0] lo, hi;

  int vec_cnt = 0;
  int err_cnt = 0;

  divider_32 #(.DIV(DIV), .DIVU(DIVU)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .busy     (busy),
    .done     (done),
    .lo       (lo),
    .hi       (hi),
    .div_zero (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  sel;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_dz;
    int          exp_lat;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed divide via 64-bit truncating arithmetic, so the
  // most-negative / -1 case needs no special handling.
  task automatic ref_div(input logic [31:0] ra, input logic [31:0] rb, input logic [5:0] rsel,
                         output logic [31:0] rlo, output logic [31:0] rhi, output logic rdz);
    longint sa, sb, qq, rr;
    if (rb == 32'd0) begin
      rlo = 32'hFFFF_FFFF;
      rhi = ra;
      rdz = 1'b1;
    end else begin
      if (rsel == DIV) begin
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
      end else begin
        sa = longint'({32'd0, ra});
        sb = longint'({32'd0, rb});
      end
      qq  = sa / sb;
      rr  = sa % sb;
      rlo = qq[31:0];
      rhi = rr[31:0];
      rdz = 1'b0;
    end
  endtask

  // Called on a falling edge: the next rising edge is the acceptance edge.
  // Operands are scrambled afterwards to prove they were latched.
  task automatic launch(input logic [31:0] la, input logic [31:0] lb, input logic [5:0] lsel);
    a     = la;
    b     = lb;
    sel   = lsel;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sel   = 6'($urandom);
  endtask

  // Starts on the first falling edge after acceptance; returns edges-to-done
  // (-1 on timeout) and whether busy was wrong at any sampled point.
  task automatic wait_done(output int lat, output logic busy_bad);
    int n;
    n        = 1;
    busy_bad = 1'b0;
    while (!done && n < 45) begin
      if (!busy) busy_bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (done) begin
      if (busy) busy_bad = 1'b1;
      lat = n - 1;
    end else begin
      lat = -1;
    end
  endtask

  task automatic count_dones(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) cnt++;
    end
  endtask

  task automatic run_and_check(input string name, input logic [31:0] ta, input logic [31:0] tb,
                               input logic [5:0] tsel, input logic [31:0] elo,
                               input logic [31:0] ehi, input logic edz, input int elat);
    int   lat;
    logic bb;
    launch(ta, tb, tsel);
    wait_done(lat, bb);
    chk({name, " latency"}, lat, elat);
    chk({name, " busy"}, {31'd0, bb}, 32'd0);
    chk({name, " lo"}, lo, elo);
    chk({name, " hi"}, hi, ehi);
    chk({name, " div_zero"}, {31'd0, div_zero}, {31'd0, edz});
  endtask

  initial begin
    int          lat, nd;
    logic        bb;
    logic [31:0] ra, rb, mlo, mhi;
    logic [5:0]  rs;
    logic        mdz;

    tbl[0] = '{32'd100,        32'd7,          DIVU, 32'd14,         32'd2,          1'b0, 33};
    tbl[1] = '{32'hFFFF_FFF9,  32'd2,          DIV,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 33};
    tbl[2] = '{32'd7,          32'hFFFF_FFFE,  DIV,  32'hFFFF_FFFD,  32'd1,          1'b0, 33};
    tbl[3] = '{32'h1234_5678,  32'd0,          DIVU, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 1};
    tbl[4] = '{32'd9,          32'd3,          DIVU, 32'd3,          32'd0,          1'b0, 33};
    tbl[5] = '{32'h8000_0000,  32'hFFFF_FFFF,  DIV,  32'h8000_0000,  32'd0,          1'b0, 33};
    tbl[6] = '{32'hFFFF_FFFF,  32'd1,          DIVU, 32'hFFFF_FFFF,  32'd0,          1'b0, 33};
    tbl[7] = '{32'hFFFF_FF9C,  32'd0,          DIV,  32'hFFFF_FFFF,  32'hFFFF_FF9C,  1'b1, 1};
    tbl[8] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  DIVU, 32'd1,          32'd0,          1'b0, 33};

    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    sel   = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset lo", lo, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset div_zero", {31'd0, div_zero}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed table, issued back-to-back from each done cycle
    foreach (tbl[i])
      run_and_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].sel,
                    tbl[i].exp_lo, tbl[i].exp_hi, tbl[i].exp_dz, tbl[i].exp_lat);

    // start while busy must be ignored
    @(negedge clk);
    launch(32'd1000, 32'd10, DIVU);
    repeat (5) @(negedge clk);
    a = 32'd5; b = 32'd1; sel = DIVU; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat, bb);
    chk("busy-start done seen", {31'd0, done}, 32'd1);
    chk("busy-start lo", lo, 32'd100);
    chk("busy-start hi", hi, 32'd0);
    count_dones(40, nd);
    chk("busy-start extra dones", nd, 32'd0);

    // unsupported function code is never accepted
    a = 32'd77; b = 32'd7; sel = 6'd32; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("sel32 busy", {31'd0, busy}, 32'd0);
    count_dones(40, nd);
    chk("sel32 dones", nd, 32'd0);
    chk("sel32 lo held", lo, 32'd100);

    // asynchronous reset in the middle of CALC
    launch(32'd1000, 32'd3, DIVU);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midreset busy", {31'd0, busy}, 32'd0);
    chk("midreset done", {31'd0, done}, 32'd0);
    chk("midreset lo", lo, 32'd0);
    chk("midreset hi", hi, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    count_dones(40, nd);
    chk("midreset dones", nd, 32'd0);
    run_and_check("post-reset", 32'd50, 32'd5, DIVU, 32'd10, 32'd0, 1'b0, 33);

    // Randomized back-to-back divides against the reference model
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      rs = ($urandom_range(0, 1) == 0) ? DIV : DIVU;
      ref_div(ra, rb, rs, mlo, mhi, mdz);
      run_and_check($sformatf("rand%0d", i), ra, rb, rs, mlo, mhi, mdz, (rb == 32'd0) ? 1 : 33);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
